cache_pmem_arbiter: RTL

- Shares the single cacheline adaptor / physical-memory port between the instruction cache and the data cache.
- Grants whole cacheline transactions (one 256-bit read or write) to one cache at a time.
- Uses round-robin priority under contention.
- Sits between Icache/Dcache controllers' pmem_* interfaces and the cacheline adaptor.

---
 rtl/cache_pmem_arbiter.sv | 111 +++++++++++
 1 files changed

// File: rtl/cache_pmem_arbiter.sv
// rtl/cache_pmem_arbiter.sv - round-robin arbiter sharing one pmem port between Icache and Dcache
// Whole-line transactions are granted one at a time; responses pass straight through.
module cache_pmem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_pmem_read,
    input  logic [ADDR_W-1:0] i_pmem_address,
    output logic [LINE_W-1:0] i_pmem_rdata,
    output logic              i_pmem_resp,
    input  logic              d_pmem_read,
    input  logic              d_pmem_write,
    input  logic [ADDR_W-1:0] d_pmem_address,
    input  logic [LINE_W-1:0] d_pmem_wdata,
    output logic [LINE_W-1:0] d_pmem_rdata,
    output logic              d_pmem_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_e;

    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

    state_e state_q, state_d;
    logic   last_grant_q, last_grant_d;
    logic   i_req, d_req;

    assign i_req = i_pmem_read;
    assign d_req = d_pmem_read | d_pmem_write;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        unique case (state_q)
            IDLE: begin
                if (i_req && d_req) begin
                    state_d = (last_grant_q == GRANT_D) ? SERVE_I : SERVE_D;
                end else if (i_req) begin
                    state_d = SERVE_I;
                end else if (d_req) begin
                    state_d = SERVE_D;
                end
            end
            // An owner that drops its request without a response is released too.
            SERVE_I: begin
                if (pmem_resp || !i_req) begin
                    state_d      = IDLE;
                    last_grant_d = GRANT_I;
                end
            end
            SERVE_D: begin
                if (pmem_resp || !d_req) begin
                    state_d      = IDLE;
                    last_grant_d = GRANT_D;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= GRANT_D;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    always_comb begin
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = d_pmem_address;
        pmem_wdata   = d_pmem_wdata;
        i_pmem_resp  = 1'b0;
        d_pmem_resp  = 1'b0;
        unique case (state_q)
            SERVE_I: begin
                pmem_read    = i_pmem_read;
                pmem_address = i_pmem_address;
                i_pmem_resp  = pmem_resp;
            end
            SERVE_D: begin
                pmem_read   = d_pmem_read;
                pmem_write  = d_pmem_write;
                d_pmem_resp = pmem_resp;
            end
            default: begin
            end
        endcase
    end

    assign i_pmem_rdata = pmem_rdata;
    assign d_pmem_rdata = pmem_rdata;

endmodule
